// File: rtl/mmu_pkg.sv
// ------------------------------------------------------------------
// mmu_pkg: shared types, address constants and decode helpers for
// the OAM DMA controller and its bus mux.           Rev 1.0
// ------------------------------------------------------------------
`default_nettype none

package mmu_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    RD    = 2'd2,
    WR    = 2'd3
  } dma_state_t;

  localparam logic [15:0] HRAM_LO      = 16'hFF80;
  localparam logic [15:0] DMA_REG_ADDR = 16'hFF46;
  localparam logic [15:0] OAM_BASE     = 16'hFE00;
  localparam int unsigned XFER_LEN     = 160;
  localparam logic [7:0]  ECHO_LO      = 8'hE0;
  localparam logic [7:0]  ECHO_OFFSET  = 8'h20;

  function automatic logic is_hram(input logic [15:0] addr);
    return (addr >= HRAM_LO);
  endfunction

  // Source pages E0..FF alias the work RAM 0x20 pages lower.
  function automatic logic [7:0] echo_map(input logic [7:0] page);
    return (page >= ECHO_LO) ? (page - ECHO_OFFSET) : page;
  endfunction

endpackage

`default_nettype wire

// File: rtl/dma_bus_mux.sv
// ------------------------------------------------------------------
// dma_bus_mux: combinational steering of CPU and DMA requests onto
// the mem_* and hram_* ports. Build option: DMA_BUS_LOCK_EN.  Rev 1.0
// ------------------------------------------------------------------
`default_nettype none

module dma_bus_mux
  import mmu_pkg::*;
#(
  parameter logic [15:0] REG_ADDR = 16'hFF46
) (
  input  logic        i_en,
  input  logic [15:0] i_cpu_addr,
  input  logic [7:0]  i_cpu_wdata,
  input  logic        i_cpu_rd,
  input  logic        i_cpu_wr,
  output logic [7:0]  o_cpu_rdata,
  input  logic        i_dma_busy,
  input  logic        i_dma_rd,
  input  logic        i_dma_wr,
  input  logic [15:0] i_dma_addr,
  input  logic [7:0]  i_dma_wdata,
  input  logic [7:0]  i_src_reg,
  output logic [15:0] o_mem_addr,
  output logic [7:0]  o_mem_wdata,
  output logic        o_mem_rd,
  output logic        o_mem_wr,
  input  logic [7:0]  i_mem_rdata,
  output logic [15:0] o_hram_addr,
  output logic [7:0]  o_hram_wdata,
  output logic        o_hram_rd,
  output logic        o_hram_wr,
  input  logic [7:0]  i_hram_rdata,
  output logic        o_reg_wr,
  output logic        o_conflict
);

  logic w_acc;
  logic w_hram_hit;
  logic w_reg_hit;
  logic w_other;
  logic w_cpu_to_mem;

  assign w_acc      = i_en && (i_cpu_rd || i_cpu_wr);
  assign w_hram_hit = is_hram(i_cpu_addr);
  assign w_reg_hit  = (i_cpu_addr == REG_ADDR);
  assign w_other    = w_acc && !w_hram_hit && !w_reg_hit;
  assign o_conflict = w_other && i_dma_busy;
  assign o_reg_wr   = i_en && i_cpu_wr && w_reg_hit;

`ifdef DMA_BUS_LOCK_EN
  assign w_cpu_to_mem = w_other && !i_dma_busy;
`else
  // The CPU owns mem_* whenever it asks; the controller stalls instead.
  assign w_cpu_to_mem = w_other;
`endif

  always_comb begin
    o_mem_addr  = 16'h0000;
    o_mem_wdata = 8'h00;
    o_mem_rd    = 1'b0;
    o_mem_wr    = 1'b0;
    if (w_cpu_to_mem) begin
      o_mem_addr  = i_cpu_addr;
      o_mem_wdata = i_cpu_wdata;
      o_mem_rd    = i_cpu_rd;
      o_mem_wr    = i_cpu_wr;
    end else if (i_en && (i_dma_rd || i_dma_wr)) begin
      o_mem_addr  = i_dma_addr;
      o_mem_wdata = i_dma_wr ? i_dma_wdata : 8'h00;
      o_mem_rd    = i_dma_rd;
      o_mem_wr    = i_dma_wr;
    end
  end

  always_comb begin
    o_hram_addr  = 16'h0000;
    o_hram_wdata = 8'h00;
    o_hram_rd    = 1'b0;
    o_hram_wr    = 1'b0;
    if (w_acc && w_hram_hit) begin
      o_hram_addr  = i_cpu_addr;
      o_hram_wdata = i_cpu_wdata;
      o_hram_rd    = i_cpu_rd;
      o_hram_wr    = i_cpu_wr;
    end
  end

  always_comb begin
    o_cpu_rdata = 8'hFF;
    if (i_en && i_cpu_rd) begin
      if (w_reg_hit) begin
        o_cpu_rdata = i_src_reg;
      end else if (w_hram_hit) begin
        o_cpu_rdata = i_hram_rdata;
      end else if (w_cpu_to_mem) begin
        o_cpu_rdata = i_mem_rdata;
      end
    end
  end

endmodule

`default_nettype wire

// File: rtl/oam_dma_ctrl.sv
// ------------------------------------------------------------------
// oam_dma_ctrl: OAM DMA sequencer and CPU/DMA bus arbiter.
// Build option: DMA_BUS_LOCK_EN (DMA owns mem_* while busy). Rev 1.0
// ------------------------------------------------------------------
`default_nettype none

module oam_dma_ctrl #(
  parameter logic [15:0] DMA_REG_ADDR = 16'hFF46,
  parameter logic [15:0] OAM_BASE     = 16'hFE00,
  parameter int unsigned XFER_LEN     = 160
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic [15:0] cpu_addr,
  input  logic [7:0]  cpu_wdata,
  input  logic        cpu_read_en,
  input  logic        cpu_write_en,
  output logic [7:0]  cpu_rdata,
  output logic [15:0] mem_addr,
  output logic [7:0]  mem_wdata,
  output logic        mem_read_en,
  output logic        mem_write_en,
  input  logic [7:0]  mem_rdata,
  output logic [15:0] hram_addr,
  output logic [7:0]  hram_wdata,
  output logic        hram_read_en,
  output logic        hram_write_en,
  input  logic [7:0]  hram_rdata,
  output logic        dma_active
);

  import mmu_pkg::*;

  localparam logic [1:0] c_ST_IDLE  = IDLE;
  localparam logic [1:0] c_ST_START = START;
  localparam logic [1:0] c_ST_RD    = RD;
  localparam logic [1:0] c_ST_WR    = WR;
  localparam logic [7:0] c_LAST_IDX = 8'(XFER_LEN - 1);

  logic [1:0]  r_state;
  logic [1:0]  w_state_nxt;
  logic [7:0]  r_idx;
  logic [7:0]  w_idx_nxt;
  logic [7:0]  r_buf;
  logic [7:0]  r_src;
  logic        r_active;

  logic        w_trigger;
  logic        w_conflict;
  logic        w_stall;
  logic        w_busy;
  logic        w_dma_rd;
  logic        w_dma_wr;
  logic [7:0]  w_src_eff;
  logic [15:0] w_dma_addr;

`ifdef DMA_BUS_LOCK_EN
  logic w_conflict_unused;
  assign w_conflict_unused = w_conflict;
  assign w_stall           = 1'b0;
`else
  assign w_stall = w_conflict;
`endif

  assign w_busy     = (r_state != c_ST_IDLE);
  assign w_dma_rd   = (r_state == c_ST_RD) && !w_stall;
  assign w_dma_wr   = (r_state == c_ST_WR) && !w_stall;
  assign w_src_eff  = echo_map(r_src);
  assign w_dma_addr = (r_state == c_ST_WR) ? (OAM_BASE + {8'h00, r_idx})
                                           : {w_src_eff, r_idx};
  assign dma_active = r_active;

  // A trigger outranks everything, including the final write of a transfer.
  always_comb begin
    w_state_nxt = r_state;
    w_idx_nxt   = r_idx;
    if (w_trigger) begin
      w_state_nxt = c_ST_START;
      w_idx_nxt   = 8'h00;
    end else if (!w_stall) begin
      case (r_state)
        c_ST_START: w_state_nxt = c_ST_RD;
        c_ST_RD:    w_state_nxt = c_ST_WR;
        c_ST_WR: begin
          if (r_idx < c_LAST_IDX) begin
            w_state_nxt = c_ST_RD;
            w_idx_nxt   = r_idx + 8'h01;
          end else begin
            w_state_nxt = c_ST_IDLE;
            w_idx_nxt   = 8'h00;
          end
        end
        default: w_state_nxt = c_ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state  <= c_ST_IDLE;
      r_idx    <= 8'h00;
      r_buf    <= 8'h00;
      r_src    <= 8'hFF;
      r_active <= 1'b0;
    end else begin
      r_state  <= w_state_nxt;
      r_idx    <= w_idx_nxt;
      r_active <= (w_state_nxt != c_ST_IDLE);
      if (w_trigger) begin
        r_src <= cpu_wdata;
      end
      if (w_dma_rd) begin
        r_buf <= mem_rdata;
      end
    end
  end

  dma_bus_mux #(
    .REG_ADDR (DMA_REG_ADDR)
  ) u_bus_mux (
    .i_en         (reset_n),
    .i_cpu_addr   (cpu_addr),
    .i_cpu_wdata  (cpu_wdata),
    .i_cpu_rd     (cpu_read_en),
    .i_cpu_wr     (cpu_write_en),
    .o_cpu_rdata  (cpu_rdata),
    .i_dma_busy   (w_busy),
    .i_dma_rd     (w_dma_rd),
    .i_dma_wr     (w_dma_wr),
    .i_dma_addr   (w_dma_addr),
    .i_dma_wdata  (r_buf),
    .i_src_reg    (r_src),
    .o_mem_addr   (mem_addr),
    .o_mem_wdata  (mem_wdata),
    .o_mem_rd     (mem_read_en),
    .o_mem_wr     (mem_write_en),
    .i_mem_rdata  (mem_rdata),
    .o_hram_addr  (hram_addr),
    .o_hram_wdata (hram_wdata),
    .o_hram_rd    (hram_read_en),
    .o_hram_wr    (hram_write_en),
    .i_hram_rdata (hram_rdata),
    .o_reg_wr     (w_trigger),
    .o_conflict   (w_conflict)
  );

endmodule

`default_nettype wire

// File: tb/tb_oam_dma_ctrl.sv
// ------------------------------------------------------------------
// tb_oam_dma_ctrl: self-checking bench for oam_dma_ctrl against a
// byte-level memory model and a transfer-progress model.     Rev 1.0
// ------------------------------------------------------------------
`default_nettype none

module tb_oam_dma_ctrl;

  logic        clk = 1'b0;
  logic        reset_n;
  logic [15:0] cpu_addr;
  logic [7:0]  cpu_wdata;
  logic        cpu_read_en;
  logic        cpu_write_en;
  logic [7:0]  cpu_rdata;
  logic [15:0] mem_addr;
  logic [7:0]  mem_wdata;
  logic        mem_read_en;
  logic        mem_write_en;
  logic [7:0]  mem_rdata;
  logic [15:0] hram_addr;
  logic [7:0]  hram_wdata;
  logic        hram_read_en;
  logic        hram_write_en;
  logic [7:0]  hram_rdata;
  logic        dma_active;

  logic [7:0]  mem_model  [0:65535];
  logic [7:0]  hram_model [0:127];
  logic [7:0]  src_model;
  int          n_checks = 0;
  int          n_errors = 0;

`ifdef DMA_BUS_LOCK_EN
  localparam bit LOCK = 1'b1;
`else
  localparam bit LOCK = 1'b0;
`endif

  localparam int EV_NONE     = 0;
  localparam int EV_CONFLICT = 1;
  localparam int EV_HRAM     = 2;
  localparam int EV_REGRD    = 3;
  localparam int EV_RETRIG   = 4;
  localparam int EV_RESET    = 5;

  oam_dma_ctrl dut (
    .clk           (clk),
    .reset_n       (reset_n),
    .cpu_addr      (cpu_addr),
    .cpu_wdata     (cpu_wdata),
    .cpu_read_en   (cpu_read_en),
    .cpu_write_en  (cpu_write_en),
    .cpu_rdata     (cpu_rdata),
    .mem_addr      (mem_addr),
    .mem_wdata     (mem_wdata),
    .mem_read_en   (mem_read_en),
    .mem_write_en  (mem_write_en),
    .mem_rdata     (mem_rdata),
    .hram_addr     (hram_addr),
    .hram_wdata    (hram_wdata),
    .hram_read_en  (hram_read_en),
    .hram_write_en (hram_write_en),
    .hram_rdata    (hram_rdata),
    .dma_active    (dma_active)
  );

  always #5 clk = ~clk;

  assign mem_rdata  = mem_model[mem_addr];
  assign hram_rdata = hram_model[hram_addr[6:0]];

  always @(posedge clk) begin
    if (mem_write_en)  mem_model[mem_addr] <= mem_wdata;
    if (hram_write_en) hram_model[hram_addr[6:0]] <= hram_wdata;
  end

  function automatic logic [7:0] echo(input logic [7:0] s);
    return (s >= 8'hE0) ? (s - 8'h20) : s;
  endfunction

  task automatic bus_idle();
    cpu_addr     = 16'h0000;
    cpu_wdata    = 8'h00;
    cpu_read_en  = 1'b0;
    cpu_write_en = 1'b0;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    reset_n     = 1'b0;
    bus_idle();
    cpu_addr    = 16'hC000;
    cpu_read_en = 1'b1;
    @(negedge clk);
    n_checks++;
    if ({mem_read_en, mem_write_en, hram_read_en, hram_write_en} !== 4'b0000) begin
      n_errors++;
      $display("FAIL reset_strobes: got %b expected 0000",
               {mem_read_en, mem_write_en, hram_read_en, hram_write_en});
    end
    n_checks++;
    if ({mem_addr, hram_addr, mem_wdata, hram_wdata} !== 48'h0) begin
      n_errors++;
      $display("FAIL reset_addr_data: got %h expected 0",
               {mem_addr, hram_addr, mem_wdata, hram_wdata});
    end
    n_checks++;
    if (cpu_rdata !== 8'hFF) begin
      n_errors++;
      $display("FAIL reset_cpu_rdata: got %h expected ff", cpu_rdata);
    end
    n_checks++;
    if (dma_active !== 1'b0) begin
      n_errors++;
      $display("FAIL reset_dma_active: got %b expected 0", dma_active);
    end
    step();
    reset_n   = 1'b1;
    src_model = 8'hFF;
    cpu_addr  = 16'hFF46;
    @(negedge clk);
    n_checks++;
    if (cpu_rdata !== src_model || mem_read_en !== 1'b0) begin
      n_errors++;
      $display("FAIL reset_src_reg: got rdata=%h mem_rd=%b expected ff/0", cpu_rdata, mem_read_en);
    end
    step();
    bus_idle();
  endtask

  task automatic test_idle_passthrough();
    logic [15:0] a;
    logic [7:0]  d;
    int          kind;
    mem_model[16'hC123] = 8'h5A;
    cpu_addr    = 16'hC123;
    cpu_read_en = 1'b1;
    @(negedge clk);
    n_checks++;
    if (mem_addr !== 16'hC123 || mem_read_en !== 1'b1 || cpu_rdata !== 8'h5A) begin
      n_errors++;
      $display("FAIL idle_read_c123: got addr=%h rd=%b rdata=%h expected c123/1/5a",
               mem_addr, mem_read_en, cpu_rdata);
    end
    step();
    bus_idle();
    for (int n = 0; n < 24; n++) begin
      kind = int'($urandom_range(0, 3));
      d    = 8'($urandom);
      if (kind < 2) begin
        a = 16'($urandom_range(0, 16'hFF7F));
        if (a == 16'hFF46) a = 16'hFF45;
      end else begin
        a = 16'($urandom_range(16'hFF80, 16'hFFFF));
      end
      cpu_addr     = a;
      cpu_wdata    = d;
      cpu_read_en  = (kind == 0) || (kind == 2);
      cpu_write_en = (kind == 1) || (kind == 3);
      @(negedge clk);
      n_checks++;
      case (kind)
        0: if (mem_addr !== a || mem_read_en !== 1'b1 || mem_write_en !== 1'b0 ||
               cpu_rdata !== mem_model[a] || hram_read_en !== 1'b0) begin
             n_errors++;
             $display("FAIL idle_mem_read: got addr=%h rd=%b rdata=%h expected %h/1/%h",
                      mem_addr, mem_read_en, cpu_rdata, a, mem_model[a]);
           end
        1: if (mem_addr !== a || mem_write_en !== 1'b1 || mem_wdata !== d) begin
             n_errors++;
             $display("FAIL idle_mem_write: got addr=%h wr=%b wdata=%h expected %h/1/%h",
                      mem_addr, mem_write_en, mem_wdata, a, d);
           end
        2: if (hram_addr !== a || hram_read_en !== 1'b1 || mem_read_en !== 1'b0 ||
               cpu_rdata !== hram_model[a[6:0]]) begin
             n_errors++;
             $display("FAIL idle_hram_read: got addr=%h rd=%b mem_rd=%b rdata=%h expected %h/1/0/%h",
                      hram_addr, hram_read_en, mem_read_en, cpu_rdata, a, hram_model[a[6:0]]);
           end
        default: if (hram_addr !== a || hram_write_en !== 1'b1 || hram_wdata !== d ||
                     mem_write_en !== 1'b0) begin
             n_errors++;
             $display("FAIL idle_hram_write: got addr=%h wr=%b wdata=%h mem_wr=%b expected %h/1/%h/0",
                      hram_addr, hram_write_en, hram_wdata, mem_write_en, a, d);
           end
      endcase
      step();
      bus_idle();
    end
  endtask

  // Transfer model: progress p=0 is the setup cycle, odd p reads byte
  // (p-1)/2 of the source page, even p>0 writes byte p/2-1 to OAM.
  task automatic run_xfer(input logic [7:0] src, input int ev_kind,
                          input int ev_p, input logic [7:0] ev_src);
    logic [7:0]  eff;
    logic [7:0]  oam_before [160];
    logic [15:0] ea;
    logic [7:0]  ed;
    logic [7:0]  exp_b;
    logic        er, ew, chk_addr;
    int          p, act_cnt, exp_len, n_wr;
    bit          busy, fired, ev_now, stall, rst_hit;

    for (int i = 0; i < 160; i++) oam_before[i] = mem_model[16'hFE00 + 16'(i)];
    cpu_addr     = 16'hFF46;
    cpu_wdata    = src;
    cpu_write_en = 1'b1;
    @(negedge clk);
    n_checks++;
    if ({mem_read_en, mem_write_en} !== 2'b00 || dma_active !== 1'b0) begin
      n_errors++;
      $display("FAIL trigger_cycle: got mem_rd/wr=%b active=%b expected 00/0",
               {mem_read_en, mem_write_en}, dma_active);
    end
    step();
    bus_idle();
    src_model = src;
    eff       = echo(src);
    p = 0; busy = 1'b1; fired = 1'b0; rst_hit = 1'b0;
    act_cnt = 0; exp_len = 321;

    for (int guard = 0; busy && guard < 1000; guard++) begin
      ev_now = (ev_kind != EV_NONE) && !fired && (p == ev_p);
      if (ev_now) begin
        fired = 1'b1;
        case (ev_kind)
          EV_CONFLICT: begin cpu_addr = 16'h8000; cpu_read_en = 1'b1; end
          EV_HRAM:     begin cpu_addr = 16'hFF90; cpu_wdata = 8'h77; cpu_write_en = 1'b1; end
          EV_REGRD:    begin cpu_addr = 16'hFF46; cpu_read_en = 1'b1; end
          EV_RETRIG:   begin cpu_addr = 16'hFF46; cpu_wdata = ev_src; cpu_write_en = 1'b1; end
          default:     reset_n = 1'b0;
        endcase
      end
      stall = ev_now && (ev_kind == EV_CONFLICT) && !LOCK;
      @(negedge clk);
      if (ev_now && ev_kind == EV_RESET) begin
        n_checks++;
        if ({mem_read_en, mem_write_en, hram_read_en, hram_write_en} !== 4'b0000 ||
            dma_active !== 1'b0 || cpu_rdata !== 8'hFF) begin
          n_errors++;
          $display("FAIL reset_mid_xfer: got strobes=%b active=%b rdata=%h expected 0000/0/ff",
                   {mem_read_en, mem_write_en, hram_read_en, hram_write_en}, dma_active, cpu_rdata);
        end
        step();
        reset_n   = 1'b1;
        src_model = 8'hFF;
        busy      = 1'b0;
        rst_hit   = 1'b1;
      end else begin
        if (dma_active === 1'b1) act_cnt++;
        n_checks++;
        if (dma_active !== 1'b1) begin
          n_errors++;
          $display("FAIL dma_active_p%0d: got %b expected 1", p, dma_active);
        end
        chk_addr = 1'b1; er = 1'b0; ew = 1'b0; ea = 16'h0000; ed = 8'h00;
        if (stall) begin
          er = 1'b1; ea = 16'h8000;
        end else if (p == 0) begin
          chk_addr = 1'b0;
        end else if (p % 2 == 1) begin
          er = 1'b1; ea = {eff, 8'((p - 1) / 2)};
        end else begin
          ew = 1'b1;
          ea = 16'hFE00 + 16'(p / 2 - 1);
          ed = mem_model[{eff, 8'(p / 2 - 1)}];
        end
        n_checks++;
        if ({mem_read_en, mem_write_en} !== {er, ew}) begin
          n_errors++;
          $display("FAIL mem_strobes_p%0d: got %b expected %b", p, {mem_read_en, mem_write_en}, {er, ew});
        end
        if (chk_addr) begin
          n_checks++;
          if (mem_addr !== ea) begin
            n_errors++;
            $display("FAIL mem_addr_p%0d: got %h expected %h", p, mem_addr, ea);
          end
        end
        if (ew) begin
          n_checks++;
          if (mem_wdata !== ed) begin
            n_errors++;
            $display("FAIL mem_wdata_p%0d: got %h expected %h", p, mem_wdata, ed);
          end
        end
        if (ev_now && ev_kind == EV_CONFLICT) begin
          exp_b = LOCK ? 8'hFF : mem_model[16'h8000];
          n_checks++;
          if (cpu_rdata !== exp_b) begin
            n_errors++;
            $display("FAIL conflict_rdata: got %h expected %h", cpu_rdata, exp_b);
          end
        end
        if (ev_now && ev_kind == EV_HRAM) begin
          n_checks++;
          if (hram_write_en !== 1'b1 || hram_addr !== 16'hFF90 || hram_wdata !== 8'h77) begin
            n_errors++;
            $display("FAIL hram_during_dma: got wr=%b addr=%h wdata=%h expected 1/ff90/77",
                     hram_write_en, hram_addr, hram_wdata);
          end
        end
        if (ev_now && ev_kind == EV_REGRD) begin
          n_checks++;
          if (cpu_rdata !== src_model) begin
            n_errors++;
            $display("FAIL reg_readback: got %h expected %h", cpu_rdata, src_model);
          end
        end
        step();
        bus_idle();
        if (ev_now && ev_kind == EV_RETRIG) begin
          p         = 0;
          src_model = ev_src;
          eff       = echo(ev_src);
          exp_len   = exp_len + ev_p + 1;
        end else if (stall) begin
          exp_len++;
        end else if (p == 320) begin
          busy = 1'b0;
        end else begin
          p++;
        end
      end
    end

    if (busy) begin
      n_checks++;
      n_errors++;
      $display("FAIL xfer_timeout: got busy after 1000 cycles expected done");
    end
    if (!rst_hit) begin
      @(negedge clk);
      n_checks++;
      if (dma_active !== 1'b0 || {mem_read_en, mem_write_en} !== 2'b00) begin
        n_errors++;
        $display("FAIL xfer_end_idle: got active=%b strobes=%b expected 0/00",
                 dma_active, {mem_read_en, mem_write_en});
      end
      n_checks++;
      if (act_cnt != exp_len) begin
        n_errors++;
        $display("FAIL xfer_latency: got %0d active cycles expected %0d", act_cnt, exp_len);
      end
      step();
    end else begin
      cpu_addr    = 16'hFF46;
      cpu_read_en = 1'b1;
      @(negedge clk);
      n_checks++;
      if (cpu_rdata !== 8'hFF || dma_active !== 1'b0) begin
        n_errors++;
        $display("FAIL reset_mid_src: got rdata=%h active=%b expected ff/0", cpu_rdata, dma_active);
      end
      step();
      bus_idle();
    end

    n_wr = rst_hit ? (ev_p - 1) / 2 : 160;
    for (int i = 0; i < 160; i++) begin
      exp_b = (i < n_wr) ? mem_model[{eff, 8'(i)}] : oam_before[i];
      n_checks++;
      if (mem_model[16'hFE00 + 16'(i)] !== exp_b) begin
        n_errors++;
        $display("FAIL oam_byte_%0d: got %h expected %h", i,
                 mem_model[16'hFE00 + 16'(i)], exp_b);
      end
    end
  endtask

  task automatic test_full_transfer();
    for (int i = 0; i < 256; i++) mem_model[16'hC100 + 16'(i)] = 8'(i);
    run_xfer(8'hC1, EV_NONE, 0, 8'h00);
  endtask

  task automatic test_echo_source();
    run_xfer(8'hE3, EV_NONE, 0, 8'h00);
    run_xfer(8'(32'($urandom_range(0, 255))), EV_REGRD, int'($urandom_range(1, 320)), 8'h00);
  endtask

  task automatic test_hram_during_dma();
    run_xfer(8'(32'($urandom_range(0, 255))), EV_HRAM, int'($urandom_range(1, 320)), 8'h00);
    cpu_addr    = 16'hFF90;
    cpu_read_en = 1'b1;
    @(negedge clk);
    n_checks++;
    if (cpu_rdata !== 8'h77) begin
      n_errors++;
      $display("FAIL hram_readback: got %h expected 77", cpu_rdata);
    end
    step();
    bus_idle();
  endtask

  task automatic test_conflict();
    run_xfer(8'(32'($urandom_range(0, 255))), EV_CONFLICT,
             2 * int'($urandom_range(0, 159)) + 1, 8'h00);
    run_xfer(8'(32'($urandom_range(0, 255))), EV_CONFLICT,
             2 * int'($urandom_range(1, 160)), 8'h00);
  endtask

  task automatic test_restart();
    run_xfer(8'(32'($urandom_range(0, 255))), EV_RETRIG, 101, 8'hD0);
    run_xfer(8'(32'($urandom_range(0, 255))), EV_RETRIG, 320,
             8'(32'($urandom_range(0, 255))));
  endtask

  task automatic test_reset_mid();
    run_xfer(8'(32'($urandom_range(0, 255))), EV_RESET, 161, 8'h00);
  endtask

  initial begin
    for (int i = 0; i < 65536; i++) mem_model[i] = 8'($urandom);
    for (int i = 0; i < 128; i++) hram_model[i] = 8'($urandom);
    src_model = 8'hFF;
    test_reset();
    test_idle_passthrough();
    test_full_transfer();
    test_echo_source();
    test_hram_during_dma();
    test_conflict();
    test_restart();
    test_reset_mid();
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

`default_nettype wire
